// File: rtl/mmio_io_ctrl_pkg.sv
// Shared MMIO address-map constants for the I/O controller.
// Hit decode keys on the top address nibble; register select uses addr[7:0].
package mmio_io_ctrl_pkg;

    localparam logic [3:0] IO_BASE_NIB  = 4'h8;
    localparam logic [7:0] IO_UART_CTRL = 8'h00;
    localparam logic [7:0] IO_UART_RX   = 8'h04;
    localparam logic [7:0] IO_UART_TX   = 8'h08;
    localparam logic [7:0] IO_CYC_CNT   = 8'h10;
    localparam logic [7:0] IO_INST_CNT  = 8'h14;
    localparam logic [7:0] IO_CNT_RST   = 8'h18;

    function automatic logic is_io_nib(input logic [3:0] nib);
        return nib == IO_BASE_NIB;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Register-based FIFO with combinational head output (pointer + count).
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO controller: UART RX/TX byte FIFOs plus cycle and retired-instruction
// counters, with one-cycle registered read data matching dmem latency.
module mmio_io_ctrl
    import mmio_io_ctrl_pkg::*;
#(
    parameter int unsigned RX_FIFO_DEPTH = 8,
    parameter int unsigned TX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retired,
    output logic        io_hit,
    output logic [31:0] rdata,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready
);

    logic        hit;
    logic [7:0]  off;
    logic        rd_req;
    logic        wr_req;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_dout;
    logic        rx_push;
    logic        rx_pop;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_push;
    logic        tx_pop;
    logic        cnt_clr;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] rdata_next;
    logic        unused_bits;

    assign unused_bits = ^{addr[27:8], wdata[31:8]};

    assign hit    = is_io_nib(addr[31:28]);
    assign off    = addr[7:0];
    // A simultaneous store wins over the load, so the read side stays idle.
    assign rd_req = re && !we && hit;
    assign wr_req = we && hit;

    assign uart_rx_data_out_ready = !rx_full && !rst;
    assign uart_tx_data_in_valid  = !tx_empty && !rst;

    assign rx_push = uart_rx_data_out_valid && uart_rx_data_out_ready;
    assign rx_pop  = rd_req && (off == IO_UART_RX);
    assign tx_push = wr_req && (off == IO_UART_TX);
    assign tx_pop  = uart_tx_data_in_valid && uart_tx_data_in_ready;
    assign cnt_clr = wr_req && (off == IO_CNT_RST);

    io_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (uart_rx_data_out),
        .full  (rx_full),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .empty (rx_empty)
    );

    io_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (wdata[7:0]),
        .full  (tx_full),
        .pop   (tx_pop),
        .dout  (uart_tx_data_in),
        .empty (tx_empty)
    );

    always_comb begin
        rdata_next = '0;
        if (rd_req) begin
            case (off)
                IO_UART_CTRL: rdata_next = {30'b0, !rx_empty, !tx_full};
                IO_UART_RX:   rdata_next = rx_empty ? '0 : {24'b0, rx_dout};
                IO_CYC_CNT:   rdata_next = cycle_cnt;
                IO_INST_CNT:  rdata_next = inst_cnt;
                default:      rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
            rdata     <= '0;
            io_hit    <= 1'b0;
        end else begin
            rdata  <= rdata_next;
            io_hit <= (we || re) && hit;
            if (cnt_clr) begin
                cycle_cnt <= '0;
                inst_cnt  <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
                if (inst_retired) inst_cnt <= inst_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: directed scenarios plus a random mix,
// compared against a queue-based reference model of the register map.
module tb_mmio_io_ctrl;

    localparam int RXD = 8;
    localparam int TXD = 8;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_retired;
    logic        io_hit;
    logic [31:0] rdata;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] m_cyc;
    logic [31:0] m_inst;
    logic [31:0] m_rdata;
    logic        m_hit;

    mmio_io_ctrl #(.RX_FIFO_DEPTH(RXD), .TX_FIFO_DEPTH(TXD)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .addr                   (addr),
        .wdata                  (wdata),
        .we                     (we),
        .re                     (re),
        .inst_retired           (inst_retired),
        .io_hit                 (io_hit),
        .rdata                  (rdata),
        .uart_rx_data_out       (rx_data),
        .uart_rx_data_out_valid (rx_valid),
        .uart_rx_data_out_ready (rx_ready),
        .uart_tx_data_in        (tx_data),
        .uart_tx_data_in_valid  (tx_valid),
        .uart_tx_data_in_ready  (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin : model
        int rx_n;
        int tx_n;
        logic mhit;
        logic [7:0] moff;
        logic drain;
        if (rst) begin
            rx_q.delete();
            tx_q.delete();
            m_cyc   = 32'd0;
            m_inst  = 32'd0;
            m_rdata = 32'd0;
            m_hit   = 1'b0;
        end else begin
            rx_n  = rx_q.size();
            tx_n  = tx_q.size();
            mhit  = (addr[31:28] == 4'h8);
            moff  = addr[7:0];
            m_hit = (we || re) && mhit;
            m_rdata = 32'd0;
            if (re && !we && mhit) begin
                if (moff == 8'h00) m_rdata = {30'b0, rx_n != 0, tx_n != TXD};
                else if (moff == 8'h04) begin
                    if (rx_n > 0) m_rdata = {24'b0, rx_q.pop_front()};
                end
                else if (moff == 8'h10) m_rdata = m_cyc;
                else if (moff == 8'h14) m_rdata = m_inst;
            end
            drain = (tx_n > 0) && tx_ready;
            if (drain) void'(tx_q.pop_front());
            if (we && mhit && moff == 8'h08 && (tx_n < TXD || drain))
                tx_q.push_back(wdata[7:0]);
            if (rx_valid && rx_n < RXD) rx_q.push_back(rx_data);
            if (we && mhit && moff == 8'h18) begin
                m_cyc  = 32'd0;
                m_inst = 32'd0;
            end else begin
                m_cyc  = m_cyc + 32'd1;
                m_inst = m_inst + 32'(inst_retired);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a);
        addr = a; re = 1'b1; we = 1'b0;
        tick();
        re = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1; re = 1'b0;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0;
        inst_retired = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b1;
        repeat (3) tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready); end
        checks++; if (rdata !== 32'd0 || io_hit !== 1'b0) begin errors++; $display("FAIL rst_outputs rdata=%h io_hit=%b exp 0/0", rdata, io_hit); end
        rst = 1'b0;
        #1;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_rx_ready got=%b exp=1", rx_ready); end
        do_read(32'h8000_0000);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL status_after_rst got=%h exp=00000001", rdata); end
        checks++; if (io_hit !== 1'b1) begin errors++; $display("FAIL io_hit_status got=%b exp=1", io_hit); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_valid_idle got=%b exp=0", tx_valid); end
        do_read(32'h0000_0010);
        checks++; if (io_hit !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL miss_read io_hit=%b rdata=%h exp 0/0", io_hit, rdata); end
    endtask

    task automatic test_rx_basic();
        rx_valid = 1'b1; rx_data = 8'h41; tick();
        rx_data = 8'h42; tick();
        rx_valid = 1'b0;
        do_read(32'h8000_0004);
        checks++; if (rdata !== 32'h41) begin errors++; $display("FAIL rx_first got=%h exp=41", rdata); end
        do_read(32'h8000_0004);
        checks++; if (rdata !== 32'h42) begin errors++; $display("FAIL rx_second got=%h exp=42", rdata); end
        do_read(32'h8000_0000);
        checks++; if (rdata[1] !== 1'b0) begin errors++; $display("FAIL rx_status_empty got=%b exp=0", rdata[1]); end
        do_read(32'h8000_0004);
        checks++; if (rdata !== 32'd0 || io_hit !== 1'b1) begin errors++; $display("FAIL rx_empty_read rdata=%h io_hit=%b exp 0/1", rdata, io_hit); end
    endtask

    task automatic test_rx_full();
        logic [7:0] b[9];
        for (int i = 0; i < 9; i++) b[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            rx_data = b[i]; rx_valid = 1'b1;
            checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_fill_ready[%0d] got=%b exp=1", i, rx_ready); end
            tick();
        end
        rx_data = b[8];
        for (int i = 0; i < 3; i++) begin
            checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_stall_ready[%0d] got=%b exp=0", i, rx_ready); end
            tick();
        end
        addr = 32'h8000_0004; re = 1'b1;
        tick();
        re = 1'b0;
        checks++; if (rdata !== {24'b0, b[0]}) begin errors++; $display("FAIL rx_full_pop got=%h exp=%h", rdata, b[0]); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_after_pop got=%b exp=1", rx_ready); end
        tick();
        rx_valid = 1'b0;
        for (int i = 1; i < 9; i++) begin
            do_read(32'h8000_0004);
            checks++; if (rdata !== {24'b0, b[i]}) begin errors++; $display("FAIL rx_order[%0d] got=%h exp=%h", i, rdata, b[i]); end
        end
        do_read(32'h8000_0000);
        checks++; if (rdata[1] !== 1'b0) begin errors++; $display("FAIL rx_drained_status got=%b exp=0", rdata[1]); end
    endtask

    task automatic test_tx();
        logic [7:0] exp[8];
        logic [7:0] last;
        int n;
        last = 8'($urandom_range(0, 255));
        for (int i = 0; i < 7; i++) exp[i] = 8'h55;
        exp[7] = last;
        tx_ready = 1'b0;
        addr = 32'h8000_0008; wdata = 32'h55; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        checks++; if (rdata !== 32'd0 || io_hit !== 1'b1) begin errors++; $display("FAIL we_re_both rdata=%h io_hit=%b exp 0/1", rdata, io_hit); end
        for (int i = 1; i < 8; i++) do_write(32'h8000_0008, 32'h55);
        do_read(32'h8000_0000);
        checks++; if (rdata[0] !== 1'b0) begin errors++; $display("FAIL tx_full_status got=%b exp=0", rdata[0]); end
        do_write(32'h8000_0008, 32'h55);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin errors++; $display("FAIL tx_head valid=%b data=%h exp 1/55", tx_valid, tx_data); end
        // Push and drain together while full: one 0x55 leaves, the new byte enters.
        addr = 32'h8000_0008; wdata = {24'b0, last}; we = 1'b1; tx_ready = 1'b1;
        tick();
        we = 1'b0; tx_ready = 1'b0;
        do_read(32'h8000_0000);
        checks++; if (rdata[0] !== 1'b0) begin errors++; $display("FAIL tx_full_after_swap got=%b exp=0", rdata[0]); end
        tx_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (tx_valid === 1'b1) begin
                if (n < 8) begin
                    checks++; if (tx_data !== exp[n]) begin errors++; $display("FAIL tx_drain[%0d] got=%h exp=%h", n, tx_data, exp[n]); end
                end
                n++;
            end
            tick();
        end
        checks++; if (n != 8) begin errors++; $display("FAIL tx_drain_count got=%0d exp=8", n); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty_valid got=%b exp=0", tx_valid); end
    endtask

    task automatic test_counters();
        logic pat[100];
        logic t;
        int j;
        for (int i = 0; i < 100; i++) pat[i] = (i < 40);
        for (int i = 99; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = pat[i]; pat[i] = pat[j]; pat[j] = t;
        end
        do_write(32'h8000_0018, $urandom);
        for (int i = 0; i < 100; i++) begin
            inst_retired = pat[i];
            tick();
        end
        inst_retired = 1'b0;
        do_read(32'h8000_0010);
        checks++; if (rdata !== 32'd100) begin errors++; $display("FAIL cyc_delta got=%0d exp=100", rdata); end
        do_read(32'h8000_0014);
        checks++; if (rdata !== 32'd40) begin errors++; $display("FAIL inst_delta got=%0d exp=40", rdata); end
        inst_retired = 1'b1;
        do_write(32'h8000_0018, 32'd0);
        inst_retired = 1'b0;
        do_read(32'h8000_0010);
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL cyc_after_clear got=%0d exp=0", rdata); end
        do_read(32'h8000_0014);
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL inst_clear_wins got=%0d exp=0", rdata); end
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        m_cyc = 32'hFFFF_FFFF;
        addr = 32'h8000_0010; re = 1'b1;
        #1 release dut.cycle_cnt;
        tick();
        checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_preload got=%h exp=ffffffff", rdata); end
        tick();
        re = 1'b0;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL cyc_wrap got=%h exp=00000000", rdata); end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_data = 8'($urandom_range(0, 255));
            addr = 32'h8000_0008; wdata = $urandom; we = 1'b1;
            tick();
        end
        rx_valid = 1'b0; we = 1'b0;
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_queued_valid got=%b exp=1", tx_valid); end
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin errors++; $display("FAIL in_rst tx_valid=%b rx_ready=%b exp 0/0", tx_valid, rx_ready); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL post_rst_tx_valid[%0d] got=%b exp=0", i, tx_valid); end
            tick();
        end
        do_read(32'h8000_0000);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL post_rst_status got=%h exp=00000001", rdata); end
        do_read(32'h8000_0004);
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL post_rst_rx got=%h exp=0", rdata); end
    endtask

    task automatic test_random();
        logic [7:0] offs[8];
        logic [3:0] nib;
        int op;
        offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h20};
        for (int c = 0; c < 400; c++) begin
            op  = $urandom_range(0, 3);
            nib = ($urandom_range(0, 3) != 0) ? 4'h8 : 4'($urandom_range(0, 15));
            addr = {nib, 20'($urandom), offs[$urandom_range(0, 7)]};
            if (addr[7:0] == 8'h18 && $urandom_range(0, 3) != 0) addr[7:0] = 8'h10;
            wdata = $urandom;
            we = (op == 2 || op == 3);
            re = (op == 1 || op == 3);
            rx_valid = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom_range(0, 255));
            tx_ready = ($urandom_range(0, 2) == 0);
            inst_retired = 1'($urandom_range(0, 1));
            checks++; if (tx_valid !== (tx_q.size() != 0)) begin errors++; $display("FAIL rnd_tx_valid[%0d] got=%b exp=%b", c, tx_valid, tx_q.size() != 0); end
            if (tx_q.size() != 0) begin
                checks++; if (tx_data !== tx_q[0]) begin errors++; $display("FAIL rnd_tx_data[%0d] got=%h exp=%h", c, tx_data, tx_q[0]); end
            end
            checks++; if (rx_ready !== (rx_q.size() < RXD)) begin errors++; $display("FAIL rnd_rx_ready[%0d] got=%b exp=%b", c, rx_ready, rx_q.size() < RXD); end
            tick();
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", c, rdata, m_rdata); end
            checks++; if (io_hit !== m_hit) begin errors++; $display("FAIL rnd_io_hit[%0d] got=%b exp=%b", c, io_hit, m_hit); end
        end
        we = 1'b0; re = 1'b0; rx_valid = 1'b0; inst_retired = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0;
        inst_retired = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b0;
        test_reset();
        test_rx_basic();
        test_rx_full();
        test_tx();
        test_counters();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
